// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the hazard control unit: EX operand forward selects
// and the memory-wait FSM state.
package hazard_ctrl_unit_pkg;

    // EX operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // result sitting in MEM/WB
    localparam logic [1:0] FWD_MEM = 2'b10;  // result sitting in EX/MEM

    // Memory-wait FSM state
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hcu_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the performance counters.
// rst and clr both zero the count; clr wins over inc.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count up on inc, hold at all-ones, zero on reset or clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for a 5-stage pipeline: EX operand forwarding, load-use
// stall, branch flush, data-memory wait freeze and performance counters.
//
// Handshake note: there is no valid/ready here; every control output is a
// per-cycle level. pc_write/ifid_write are enables (1 = advance),
// *_flush load a bubble, pipe_freeze holds ID/EX, EX/MEM and MEM/WB.
// Priority is reset > freeze > branch flush > load-use stall.
//
// Freeze timing: the first freeze cycle is the RUN cycle in which the access
// is in MEM. The FSM then sits in MEM_WAIT, freezing while the wait counter
// is non-zero; the counter-zero cycle is the unfrozen cycle in which the
// held access leaves MEM, so the freeze is exactly MEM_LAT cycles long and a
// following access is seen fresh back in RUN.
module hazard_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs1,
    input  logic              ifid_use_rs2,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_access,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic              pcsrc,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              pipe_freeze,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import hazard_ctrl_unit_pkg::*;

    localparam bit         LP_HAS_LAT   = (MEM_LAT != 0);
    localparam logic [3:0] LP_WAIT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    hcu_state_e r_state;
    hcu_state_e w_state_nxt;
    logic [3:0] r_wait;
    logic [3:0] w_wait_nxt;
    logic       w_freeze;
    logic       w_load_use;
    logic       w_flush_apply;

    // Forwarding select for both EX operands; x0 is never forwarded
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (!rst) begin
            if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idex_rs1)) begin
                forward_a = FWD_MEM;
            end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idex_rs1)) begin
                forward_a = FWD_WB;
            end
            if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idex_rs2)) begin
                forward_b = FWD_MEM;
            end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idex_rs2)) begin
                forward_b = FWD_WB;
            end
        end
    end

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        w_load_use = idex_mem_read && (idex_rd != '0) &&
                     ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                      (ifid_use_rs2 && (idex_rd == ifid_rs2)));
    end

    // Memory-wait FSM state and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Memory-wait FSM next state and freeze request
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_freeze    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (LP_HAS_LAT && exmem_mem_access) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = LP_WAIT_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (r_wait == 4'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_freeze   = 1'b1;
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = 4'd0;
            end
        endcase
    end

    // Pipeline enables and flushes: reset > freeze > branch flush > load-use
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        w_flush_apply = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (pcsrc) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            w_flush_apply = 1'b1;
        end else if (w_load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (!pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_flush_apply),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. u_dut uses MEM_LAT=3 / CNT_W=32,
// u_dut0 uses MEM_LAT=0 / CNT_W=4 and shares every input.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0;
    logic       ifid_use_rs1 = 1'b0, ifid_use_rs2 = 1'b0;
    logic [4:0] idex_rs1 = '0, idex_rs2 = '0, idex_rd = '0;
    logic       idex_mem_read = 1'b0;
    logic [4:0] exmem_rd = '0;
    logic       exmem_reg_write = 1'b0, exmem_mem_access = 1'b0;
    logic [4:0] memwb_rd = '0;
    logic       memwb_reg_write = 1'b0;
    logic       pcsrc = 1'b0, cnt_clr = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    logic        pc_write0, ifid_write0, ifid_flush0, idex_flush0, exmem_flush0, pipe_freeze0;
    logic [1:0]  forward_a0, forward_b0;
    logic [3:0]  cycle_cnt0, stall_cnt0, flush_cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_access(exmem_mem_access),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .pcsrc(pcsrc), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pipe_freeze(pipe_freeze),
        .forward_a(forward_a), .forward_b(forward_b),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_access(exmem_mem_access),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .pcsrc(pcsrc), .cnt_clr(cnt_clr),
        .pc_write(pc_write0), .ifid_write(ifid_write0),
        .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .exmem_flush(exmem_flush0),
        .pipe_freeze(pipe_freeze0),
        .forward_a(forward_a0), .forward_b(forward_b0),
        .cycle_cnt(cycle_cnt0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    // Clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, want end before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; return just after the edge so inputs and checks sit away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all five control outputs of u_dut at once (packed pc,ifid_w,ifid_f,idex_f,exmem_f)
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush},
              {27'd0, exp});
    endtask

    initial begin
        // ---------------- reset ----------------
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; idex_rs1 = 5'd5;
        tick();
        tick();
        check_ctrl("rst_ctrl", 5'b00111);
        check("rst_freeze", {31'd0, pipe_freeze}, 32'd0);
        check("rst_fwd_a", {30'd0, forward_a}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        exmem_rd = '0; exmem_reg_write = 1'b0; idex_rs1 = '0;
        #1;
        check_ctrl("run_idle_ctrl", 5'b11000);

        // ---------------- forwarding ----------------
        exmem_rd = 5'd5; exmem_reg_write = 1'b1;
        memwb_rd = 5'd5; memwb_reg_write = 1'b1;
        idex_rs1 = 5'd5;
        #1 check("fwd_a_mem_prio", {30'd0, forward_a}, 32'd2);
        exmem_reg_write = 1'b0;
        #1 check("fwd_a_wb", {30'd0, forward_a}, 32'd1);
        memwb_reg_write = 1'b0;
        #1 check("fwd_a_none", {30'd0, forward_a}, 32'd0);
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; idex_rs2 = 5'd0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1;
        #1 check("fwd_b_x0", {30'd0, forward_b}, 32'd0);
        memwb_rd = 5'd7; idex_rs2 = 5'd7;
        #1 check("fwd_b_wb", {30'd0, forward_b}, 32'd1);
        exmem_rd = 5'd7;
        #1 check("fwd_b_mem", {30'd0, forward_b}, 32'd2);
        exmem_rd = '0; exmem_reg_write = 1'b0; memwb_rd = '0; memwb_reg_write = 1'b0;
        idex_rs1 = '0; idex_rs2 = '0;

        // ---------------- counter clear ----------------
        tick();
        tick();
        check("cycle_cnt_run", cycle_cnt, 32'd2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cycle_cnt", cycle_cnt, 32'd0);
        check("clr_stall_cnt", stall_cnt, 32'd0);
        check("clr_flush_cnt", flush_cnt, 32'd0);

        // ---------------- load-use (K0) ----------------
        idex_mem_read = 1'b1; idex_rd = 5'd3; ifid_rs2 = 5'd3; ifid_use_rs2 = 1'b0;
        #1 check_ctrl("lu_unused_src", 5'b11000);
        ifid_use_rs2 = 1'b1;
        #1 check_ctrl("lu_stall", 5'b00010);
        tick();
        idex_mem_read = 1'b0; idex_rd = '0; ifid_rs2 = '0; ifid_use_rs2 = 1'b0;
        #1 check_ctrl("lu_one_cycle", 5'b11000);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        check("lu_cycle_cnt", cycle_cnt, 32'd1);

        // ---------------- flush vs load-use (K1) ----------------
        pcsrc = 1'b1;
        idex_mem_read = 1'b1; idex_rd = 5'd4; ifid_rs1 = 5'd4; ifid_use_rs1 = 1'b1;
        #1 check_ctrl("flush_over_lu", 5'b11111);
        tick();
        pcsrc = 1'b0;
        idex_mem_read = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_use_rs1 = 1'b0;
        #1 check("flu_stall_cnt", stall_cnt, 32'd1);
        check("flu_flush_cnt", flush_cnt, 32'd1);

        // ---------------- memory freeze, pcsrc held (K2..K5) ----------------
        exmem_mem_access = 1'b1; pcsrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("frz1_freeze_%0d", i), {31'd0, pipe_freeze}, 32'd1);
            check_ctrl($sformatf("frz1_ctrl_%0d", i), 5'b00000);
            check($sformatf("lat0_no_freeze_%0d", i), {31'd0, pipe_freeze0}, 32'd0);
            tick();
        end
        #1;
        check("frz1_released", {31'd0, pipe_freeze}, 32'd0);
        check_ctrl("frz1_pcsrc_after", 5'b11111);
        tick();

        // ---------------- back-to-back access (K6..K9) ----------------
        pcsrc = 1'b0;
        check("b2b_stall_cnt_pre", stall_cnt, 32'd4);
        check("b2b_flush_cnt_pre", flush_cnt, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("frz2_freeze_%0d", i), {31'd0, pipe_freeze}, 32'd1);
            tick();
        end
        #1 check("frz2_released", {31'd0, pipe_freeze}, 32'd0);
        tick();
        exmem_mem_access = 1'b0;
        #1 check("b2b_stall_cnt", stall_cnt, 32'd7);
        check("b2b_cycle_cnt", cycle_cnt, 32'd10);
        check_ctrl("b2b_idle", 5'b11000);

        // ---------------- reset in 2nd MEM_WAIT cycle (K10..K13) ----------------
        exmem_mem_access = 1'b1;
        tick();
        tick();
        rst = 1'b1; exmem_mem_access = 1'b0;
        #1 check_ctrl("mw_rst_ctrl", 5'b00111);
        check("mw_rst_freeze", {31'd0, pipe_freeze}, 32'd0);
        tick();
        rst = 1'b0;
        #1 check("post_rst_freeze", {31'd0, pipe_freeze}, 32'd0);
        check_ctrl("post_rst_ctrl", 5'b11000);
        check("post_rst_cycle_cnt", cycle_cnt, 32'd0);
        check("post_rst_stall_cnt", stall_cnt, 32'd0);
        check("post_rst_flush_cnt", flush_cnt, 32'd0);
        check("post_rst_cycle_cnt4", {28'd0, cycle_cnt0}, 32'd0);

        // 20 cycles from here; an access in cycle 1 proves the FSM is back in RUN
        for (int i = 0; i < 20; i++) begin
            exmem_mem_access = (i >= 1 && i <= 4);
            #1;
            check($sformatf("run20_freeze_%0d", i), {31'd0, pipe_freeze},
                  {31'd0, (i >= 1 && i <= 3)});
            check($sformatf("run20_lat0_freeze_%0d", i), {31'd0, pipe_freeze0}, 32'd0);
            tick();
        end
        exmem_mem_access = 1'b0;
        #1 check("run20_cycle_cnt", cycle_cnt, 32'd20);
        check("run20_stall_cnt", stall_cnt, 32'd3);
        check("run20_cycle_cnt4_sat", {28'd0, cycle_cnt0}, 32'd15);
        check("run20_stall_cnt4", {28'd0, stall_cnt0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MEM_LAT, default 0 (range 0..15), extra data-memory wait cycles per load/store.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; one clock domain, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ifid_rs1, ifid_rs2  in  REG_AW  source registers of the instruction in ID.
- ifid_use_rs1, ifid_use_rs2  in  1  instruction in ID reads rs1/rs2.
- idex_rs1, idex_rs2, idex_rd  in  REG_AW  source and destination registers of the instruction in EX.
- idex_mem_read  in  1  instruction in EX is a load.
- exmem_rd  in  REG_AW  destination register in MEM.
- exmem_reg_write, exmem_mem_access  in  1  MEM-stage instruction writes rd / accesses data memory.
- memwb_rd  in  REG_AW  destination register in WB.
- memwb_reg_write  in  1  WB-stage instruction writes rd.
- pcsrc  in  1  branch taken, resolved in MEM.
- cnt_clr  in  1  synchronous counter clear.
- pc_write, ifid_write  out  1  enables for the PC and IF/ID registers.
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble into that pipeline register.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- forward_a, forward_b  out  2  EX operand select.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-005 Forwarding SHALL be combinational.
- forward_a = 2'b10 when exmem_reg_write and exmem_rd!=0 and exmem_rd==idex_rs1.
- Otherwise forward_a = 2'b01 when memwb_reg_write and memwb_rd!=0 and memwb_rd==idex_rs1.
- Otherwise forward_a = 2'b00.
- forward_b uses the same rules with idex_rs2.
REQ-006 Register x0 SHALL never be forwarded.
REQ-007 Load-use hazard SHALL be detected when idex_mem_read and idex_rd!=0 and (ifid_use_rs1 and idex_rd==ifid_rs1, or ifid_use_rs2 and idex_rd==ifid_rs2).
REQ-008 On a load-use hazard, the block SHALL drive pc_write=0, ifid_write=0 and idex_flush=1 for exactly one cycle.
REQ-009 The FSM SHALL have two states, RUN and MEM_WAIT, plus a 4-bit wait counter.
REQ-010 In RUN with MEM_LAT>0 and exmem_mem_access=1, the FSM SHALL move to MEM_WAIT and load the wait counter with MEM_LAT-1.
REQ-011 In MEM_WAIT, the counter SHALL decrement each cycle, and the FSM SHALL return to RUN in the cycle after the counter reads 0.
REQ-012 The freeze SHALL last exactly MEM_LAT cycles per access, starting in the same cycle the access is in MEM.
REQ-013 While frozen, the block SHALL drive pipe_freeze=1, pc_write=0, ifid_write=0 and all flushes=0.
REQ-014 With MEM_LAT=0, the block SHALL never leave RUN and pipe_freeze SHALL stay 0.
REQ-015 With pcsrc=1 and no freeze, the block SHALL drive ifid_flush, idex_flush and exmem_flush =1 and pc_write=1 for one cycle.
REQ-016 While frozen, pcsrc SHALL be ignored; pcsrc is acted on in the first unfrozen cycle.
REQ-017 Priority SHALL be freeze > flush > load-use stall; a flush coinciding with a load-use hazard SHALL not stall.
REQ-018 Back-to-back memory accesses SHALL each receive a full MEM_LAT freeze.
REQ-019 cycle_cnt SHALL increment every cycle.
REQ-020 stall_cnt SHALL increment each cycle pc_write=0.
REQ-021 flush_cnt SHALL increment on each cycle in which the REQ-015 branch flush is applied.
REQ-022 All counters SHALL saturate at all-ones.
REQ-023 cnt_clr SHALL zero all counters, with priority over increment, and SHALL not affect the FSM.

Reset
REQ-024 While rst=1, the block SHALL force: state=RUN, wait counter=0, all counters=0, pc_write=0, ifid_write=0, all flushes=1, pipe_freeze=0, forward_a/forward_b=00.
REQ-025 A reset asserted during MEM_WAIT SHALL abandon the wait; the first cycle after reset SHALL be RUN with pipe_freeze=0.

Structure
REQ-026 A shared package SHALL hold the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the FSM state encoding.
REQ-027 Counters SHALL be built from one sub-module, sat_counter (parameter CNT_W; inputs clk, rst, clr, inc), instantiated three times.

Verification
REQ-028 A bench SHALL cover these directed scenarios:
- Fwd priority: exmem_rd=5, memwb_rd=5, both writing, idex_rs1=5 -> forward_a=10; drop exmem_reg_write -> forward_a=01.
- x0: exmem_rd=0, exmem_reg_write=1, idex_rs2=0 -> forward_b=00.
- Load-use: idex_mem_read=1, idex_rd=3, ifid_rs2=3, ifid_use_rs2=1 -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_cnt +1.
- MEM_LAT=3, single load in MEM -> pipe_freeze=1 for exactly 3 cycles; stall_cnt +3; pcsrc=1 during the freeze acted on in the cycle after the freeze ends; flush_cnt +1.
- Flush vs load-use in the same cycle -> three flushes =1, pc_write=1, stall_cnt unchanged.
- rst asserted in the 2nd MEM_WAIT cycle -> next cycle RUN, pipe_freeze=0, counters 0; CNT_W=4 run of 20 cycles -> cycle_cnt holds 15.
